// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and op classification for the multiply/divide unit.
// MULT_DIV_MADD_EN enables the multiply-accumulate op codes 7-10.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {LAT_NONE, LAT_MULT, LAT_DIV} lat_t;
    typedef enum logic {ST_IDLE, ST_RUN} mdu_state_t;

    // Which busy latency an op code occupies; LAT_NONE ops never raise Busy.
    function automatic lat_t op_latency(input logic [3:0] op);
        lat_t lat;
        lat = LAT_NONE;
        case (op)
            MDU_MULT, MDU_MULTU: lat = LAT_MULT;
            MDU_DIV, MDU_DIVU:   lat = LAT_DIV;
`ifdef MULT_DIV_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: lat = LAT_MULT;
`endif
            default: lat = LAT_NONE;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational next-{HI,LO} computation for multi-cycle MDU ops.
// Accumulate ops exist only when MULT_DIV_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, q_s, r_s;
    logic [31:0] q_u, r_u;
`ifdef MULT_DIV_MADD_EN
    logic [63:0] acc;
`endif

    always_comb begin
        prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u  = {32'b0, a} * {32'b0, b};
        // Signed divide via magnitudes so -2^31 / -1 wraps to 0x8000_0000 naturally.
        a_mag   = a[31] ? -a : a;
        b_mag   = b[31] ? -b : b;
        divisor = (b == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        q_s     = (a[31] ^ b[31]) ? -q_mag : q_mag;
        r_s     = a[31] ? -r_mag : r_mag;
        q_u     = a / ((b == 32'd0) ? 32'd1 : b);
        r_u     = a % ((b == 32'd0) ? 32'd1 : b);
        hi_next = hi;
        lo_next = lo;
        case (op)
            MDU_MULT:  {hi_next, lo_next} = prod_s;
            MDU_MULTU: {hi_next, lo_next} = prod_u;
            MDU_DIV:   if (b != 32'd0) begin hi_next = r_s; lo_next = q_s; end
            MDU_DIVU:  if (b != 32'd0) begin hi_next = r_u; lo_next = q_u; end
`ifdef MULT_DIV_MADD_EN
            MDU_MADD:  begin acc = {hi, lo} + prod_s; {hi_next, lo_next} = acc; end
            MDU_MADDU: begin acc = {hi, lo} + prod_u; {hi_next, lo_next} = acc; end
            MDU_MSUB:  begin acc = {hi, lo} - prod_s; {hi_next, lo_next} = acc; end
            MDU_MSUBU: begin acc = {hi, lo} - prod_u; {hi_next, lo_next} = acc; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: busy counter, pending result and architectural HI/LO.
// MULT_DIV_MADD_EN enables madd/maddu/msub/msubu.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [31:0]      hi_reg, hi_next, lo_reg, lo_next;
    logic [31:0]      pend_hi_reg, pend_hi_next, pend_lo_reg, pend_lo_next;
    logic [31:0]      calc_hi, calc_lo;
    lat_t             lat;

    mdu_calc u_calc (
        .op      (MDUOp),
        .a       (A),
        .b       (B),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .hi_next (calc_hi),
        .lo_next (calc_lo)
    );

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        lat          = op_latency(MDUOp);
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    if (lat != LAT_NONE) begin
                        pend_hi_next = calc_hi;
                        pend_lo_next = calc_lo;
                        count_next   = (lat == LAT_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_next   = ST_RUN;
                    end else if (MDUOp == MDU_MTHI) begin
                        hi_next = A;
                    end else if (MDUOp == MDU_MTLO) begin
                        lo_next = A;
                    end
                end
            end
            ST_RUN: begin
                // Start is ignored here; the pending result lands on the edge Busy falls.
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    hi_next    = pend_hi_reg;
                    lo_next    = pend_lo_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
        end
    end

    assign Busy = (state_reg == ST_RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO and busy lengths.
// Accumulate expectations follow MULT_DIV_MADD_EN.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then count cycles Busy stays high after the accepting edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        step();
        Start = 1'b0; MDUOp = 4'd0;
        cycles = 0;
        while (Busy && cycles < 200) begin
            cycles++;
            step();
        end
        $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", op, a, b, cycles, HI, LO);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
        step(); step();
        reset = 1'b0;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
        check("mult_cyc", cyc, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, cyc);
        check("multu_cyc", cyc, 32'd5);
        check("multu_hi", HI, 32'h1);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_cyc", cyc, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        run_op(4'd4, 32'd7, 32'd0, cyc);
        check("divu0_cyc", cyc, 32'd10);
        check("divu0_hi", HI, 32'hFFFF_FFFF);
        check("divu0_lo", LO, 32'hFFFF_FFFD);

        run_op(4'd4, 32'd100, 32'd7, cyc);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'h0);

        run_op(4'd5, 32'h1234, 32'd0, cyc);
        check("mthi_cyc", cyc, 32'd0);
        run_op(4'd6, 32'h5678, 32'd0, cyc);
        check("mtlo_cyc", cyc, 32'd0);
        check("mt_hi", HI, 32'h1234);
        check("mt_lo", LO, 32'h5678);

        // MULT with a conflicting Start mid-flight, which must be ignored.
        Start = 1'b1; MDUOp = 4'd1; A = 32'd3; B = 32'd4;
        step();
        Start = 1'b0;
        step();
        Start = 1'b1; MDUOp = 4'd4; A = 32'd100; B = 32'd7;
        step();
        Start = 1'b0; MDUOp = 4'd0;
        check("mid_hi_hold", HI, 32'h1234);
        cyc = 2;
        while (Busy && cyc < 200) begin
            cyc++;
            step();
        end
        $display("op=1 with ignored start busy_cycles=%0d hi=%h lo=%h", cyc, HI, LO);
        check("ign_cyc", cyc, 32'd5);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd12);

        run_op(4'd12, 32'hDEAD, 32'hBEEF, cyc);
        check("nop_cyc", cyc, 32'd0);
        check("nop_lo", LO, 32'd12);

        run_op(4'd5, 32'h0, 32'd0, cyc);
        run_op(4'd6, 32'hFFFF_FFFF, 32'd0, cyc);
        run_op(4'd8, 32'd1, 32'd1, cyc);
`ifdef MULT_DIV_MADD_EN
        check("maddu_cyc", cyc, 32'd5);
        check("maddu_hi", HI, 32'h1);
        check("maddu_lo", LO, 32'h0);
        run_op(4'd9, 32'd2, 32'd3, cyc);
        check("msub_hi", HI, 32'h0);
        check("msub_lo", LO, 32'hFFFF_FFFA);
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1, cyc);
        check("madd_hi", HI, 32'h0);
        check("madd_lo", LO, 32'hFFFF_FFF9);
`else
        check("maddu_cyc", cyc, 32'd0);
        check("maddu_hi", HI, 32'h0);
        check("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

        // Reset during the 4th busy cycle of a divide.
        Start = 1'b1; MDUOp = 4'd4; A = 32'd100; B = 32'd7;
        step();
        Start = 1'b0; MDUOp = 4'd0;
        step(); step(); step();
        check("pre_rst_busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("reset mid-divide busy=%b hi=%h lo=%h", Busy, HI, LO);
        check("mrst_busy", 32'(Busy), 32'd0);
        check("mrst_hi", HI, 32'h0);
        check("mrst_lo", LO, 32'h0);
        repeat (12) step();
        check("late_hi", HI, 32'h0);
        check("late_lo", LO, 32'h0);
        check("late_busy", 32'(Busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, living in the EX stage of the five-stage pipeline beside the ALU. It accepts one MDU instruction per Start pulse, models the fixed multiply/divide latency with a busy counter, and updates HI/LO on completion. HI/LO feed the EX result mux, so mfhi/mflo values flow into EX_MEM like any ALU result. Busy is consumed by the hazard unit to stall MDU instructions in ID.

## Interface
- MULT_CYCLES, 5, Busy duration of mult/multu/madd/maddu/msub/msubu (≥1)
- DIV_CYCLES, 10, Busy duration of div/divu (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Start  input  1  accept MDUOp this cycle (qualified by EX-stage valid instruction)
- MDUOp  input  4  operation code (see Operation)
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- Busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 treated as NONE.
- Accept = Start & ~Busy. Start while Busy is ignored entirely (no state change); the hazard unit guarantees this does not occur for valid instructions.
- On accept, result is computed from A/B (and current HI/LO for madd/msub) and held in pending registers; counter loaded with MULT_CYCLES or DIV_CYCLES.
- MULT: {HI,LO} = signed A × signed B (64-bit). MULTU: unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with dividend's sign. DIVU: unsigned. -2^31 / -1: LO = 0x8000_0000, HI = 0.
- Divide by zero (B = 0, DIV or DIVU): accepted, Busy for DIV_CYCLES, HI/LO left unchanged at completion.
- MADD/MADDU: {HI,LO} += product (signed/unsigned), 64-bit wrap-around. MSUB/MSUBU: {HI,LO} −= product, wrap-around.
- MTHI/MTLO: HI (resp. LO) ← A at the accepting edge; no Busy; other register untouched.
- NONE with Start: no effect.
- States: IDLE (counter = 0, Busy = 0), RUN (counter > 0, Busy = 1). Counter decrements each cycle in RUN; transition RUN→IDLE writes pending HI/LO.

## Timing
- Reset values: Busy = 0, HI = 0, LO = 0, counter = 0, pending cleared.
- Accept at edge T0 → Busy = 1 from T0 through edge T0+N (N = cycle parameter); HI/LO updated at edge T0+N, same edge Busy falls. Back-to-back accept allowed at the first cycle Busy = 0.
- MTHI/MTLO: visible on HI/LO the cycle after accept.
- HI/LO are registered outputs; they never change mid-operation (an mfhi issued during Busy must be stalled upstream).
- Reset mid-operation: operation discarded, Busy = 0, HI/LO = 0 at the reset edge.
- Reset and Start same cycle: reset wins.

## Configuration
- MULT_DIV_MADD_EN defined: op codes 7–10 implemented as above.
- Undefined: op codes 7–10 treated as NONE (no Busy, no HI/LO change); accumulate adder/subtractor not synthesized.

## Structure
- Shared package mdu_pkg: 4-bit op code localparams (MDU_NONE … MDU_MSUBU), default latency constants.
- One sub-module natural: mdu_calc, combinational, computing next {HI,LO} from op, A, B, HI, LO; mult_div_unit holds counter, pending registers, HI/LO.

## Test plan
- reset, then MULT A=0xFFFF_FFFE (−2), B=3 → Busy high 5 cycles; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA on Busy fall.
- MULTU A=0xFFFF_FFFF, B=2 → HI=1, LO=0xFFFF_FFFE after 5 cycles.
- DIV A=−7, B=2 → after 10 cycles LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU A=7, B=0 → Busy 10 cycles, HI/LO unchanged.
- MTHI A=0x1234, next cycle MTLO A=0x5678 → HI=0x1234, LO=0x5678, Busy never asserted; Start pulse while Busy during MULT → ignored, result matches single op.
- With MULT_DIV_MADD_EN: HI=0, LO=0xFFFF_FFFF, MADDU A=1, B=1 → HI=1, LO=0 after 5 cycles; without macro same stimulus → no change, Busy stays 0.
- DIV in flight, reset asserted at 4th Busy cycle → Busy=0, HI=LO=0 next cycle; no later write.
